// File: rtl/pipeline_result_acc.sv
// Frame accumulator for the multiply pipeline result stream: running sum and unsigned max over N samples,
// presented on a valid/ready port. Define PIPELINE_RESULT_ACC_SAT_EN for a saturating sum with a sticky sat flag.
module pipeline_result_acc #(
   parameter int DW = 16,
   parameter int N  = 8,
   parameter int SW = 24
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   input  logic [DW-1:0] in_data,
   input  logic          clr,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [SW-1:0] sum,
   output logic [DW-1:0] max,
   output logic          overrun,
   output logic          sat
);
   localparam int CW = $clog2(N+1);
   localparam logic [CW-1:0] LAST = CW'(N-1);

   typedef enum logic {ACC, HOLD} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic          accept;
   logic [SW:0]   sum_ext;

   // A held frame may be consumed and replaced by a new sample 0 on the same edge.
   assign accept  = in_valid && (state == ACC || out_ready);
   assign sum_ext = {1'b0, sum} + (SW+1)'(in_data);

`ifndef PIPELINE_RESULT_ACC_SAT_EN
   assign sat = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ACC;
         cnt       <= '0;
         sum       <= '0;
         max       <= '0;
         out_valid <= 1'b0;
         overrun   <= 1'b0;
`ifdef PIPELINE_RESULT_ACC_SAT_EN
         sat       <= 1'b0;
`endif
      end else if (clr) begin
         state     <= ACC;
         cnt       <= '0;
         sum       <= '0;
         max       <= '0;
         out_valid <= 1'b0;
         overrun   <= 1'b0;
`ifdef PIPELINE_RESULT_ACC_SAT_EN
         sat       <= 1'b0;
`endif
      end else begin
         if (state == HOLD && out_ready) begin
            state     <= ACC;
            out_valid <= 1'b0;
         end
         if (state == HOLD && !out_ready && in_valid)
            overrun <= 1'b1;
         if (accept) begin
            if (cnt == '0) begin
               sum <= SW'(in_data);
               max <= in_data;
`ifdef PIPELINE_RESULT_ACC_SAT_EN
               sat <= 1'b0;
`endif
            end else begin
`ifdef PIPELINE_RESULT_ACC_SAT_EN
               if (sum_ext[SW]) begin
                  sum <= '1;
                  sat <= 1'b1;
               end else begin
                  sum <= sum_ext[SW-1:0];
               end
`else
               sum <= sum_ext[SW-1:0];
`endif
               if (in_data > max)
                  max <= in_data;
            end
            // N >= 2, so a sample accepted out of HOLD is never the last one.
            if (cnt == LAST) begin
               cnt       <= '0;
               state     <= HOLD;
               out_valid <= 1'b1;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end
endmodule

// File: doc/pipeline_result_acc.md
# pipeline_result_acc

Downstream consumer of the 16-bit multiply pipeline result stream. Accepts one qualified result per cycle and accumulates a frame of `N` results into a running sum and running maximum. At frame end it presents `{sum, max}` on a valid/ready output port, holding the values until they are taken. An overrun flag is raised when results arrive while a completed frame is still waiting to be taken.

## Interface
Parameters:
- `DW`, 16, width of incoming result (matches pipeline `out`)
- `N`, 8, samples per frame, legal range 2..256
- `SW`, 24, sum width, must be ≥ `DW`

Ports:
- `clk`  in  1  clock, all registers positive-edge triggered
- `rst_n`  in  1  reset, asynchronous, active-low
- `in_valid`  in  1  `in_data` holds a real pipeline result this cycle; upstream aligns it to pipeline latency
- `in_data`  in  DW  pipeline result
- `clr`  in  1  synchronous frame abort / flag clear
- `out_valid`  out  1  `sum`/`max` hold a completed frame
- `out_ready`  in  1  consumer takes the frame this cycle
- `sum`  out  SW  frame sum
- `max`  out  DW  largest sample in frame, unsigned
- `overrun`  out  1  sticky: at least one sample dropped
- `sat`  out  1  sticky: sum saturated in the current frame (see Configuration)

## Operation
- States: `ACC` (collecting) and `HOLD` (frame presented).
- Sample counter `cnt` is `ceil(log2(N+1))` bits wide.
- Accept condition: `in_valid && (state==ACC || (state==HOLD && out_ready))`.
- Accepted sample, `cnt==0`: `sum <= zero-extended in_data`, `max <= in_data`.
- Accepted sample, `cnt>0`: `sum <= sum + in_data`, zero-extended to SW bits; `max <= (in_data > max) ? in_data : max`, unsigned compare.
- Accepted sample with `cnt == N-1`: state goes to `HOLD`, `cnt <= 0`. Otherwise `cnt <= cnt+1`.
- `HOLD && out_ready`: the frame is consumed and state goes to `ACC`.
- `HOLD && out_ready && in_valid` in the same cycle: the frame is consumed and the sample is accepted as sample 0 of the next frame. No drop occurs.
- `HOLD && !out_ready && in_valid`: the sample is discarded and `overrun <= 1`. `sum`/`max` are unchanged.
- `ACC` with `!in_valid`: all registers hold. Gaps between samples are unlimited.
- `out_valid` is 1 only in `HOLD`.
- While in `ACC`, `sum`/`max` show the partial frame. Their value is don't-care to the consumer.
- `clr` has priority over every other action. It forces `ACC`, `cnt=0`, `sum=0`, `max=0`, `overrun=0`, `sat=0`, and `out_valid=0`. A frame held in `HOLD` is discarded.

## Timing
- Reset values: `state=ACC`, `cnt=0`, `sum=0`, `max=0`, `out_valid=0`, `overrun=0`, `sat=0`.
- Reset assertion takes effect immediately, without waiting for a clock edge. Reset mid-frame discards the partial frame.
- Latency: `out_valid` rises on the same edge that accepts sample `N-1`. The final sum and max are visible on that cycle's outputs.
- Throughput: back-to-back frames run with no bubble when `out_ready=1` throughout. Throughput is N results per N cycles.
- Output stability: while `out_valid && !out_ready`, `sum`, `max`, and `out_valid` hold constant.
- `out_valid` never depends combinationally on `out_ready`.
- `overrun` updates on the edge of the dropped sample. It clears only on `clr` or reset.

## Configuration
- Macro: `PIPELINE_RESULT_ACC_SAT_EN`.
- Defined: an addition that would exceed `2^SW-1` clamps `sum` to all ones and sets `sat`. `sat` clears when sample 0 of the next frame is accepted, or on `clr`/reset.
- Undefined: the sum wraps modulo `2^SW`, and `sat` is tied to 0.
- Frame timing and handshake are identical in both builds.

## Test plan
- Basic frame: `N=8`, `out_ready=1`, `in_data` = 1..8 on consecutive cycles → `out_valid=1` for one cycle with `sum=36` and `max=8`. The next frame starts with no gap.
- Backpressure/overrun: after a frame completes, hold `out_ready=0` for 5 cycles with `in_valid=1` → 5 samples dropped, `overrun=1`, `sum`/`max` unchanged. Raise `out_ready` → the handshake completes, and the same-cycle sample is accepted as sample 0.
- Gapped input: samples 0x0100 and 0xFFFF interleaved with `in_valid=0` bubbles, `N=4`, data {0x0100, 0xFFFF, 0x0002, 0x0003} → `sum=0x010104`, `max=0xFFFF`.
- Width boundary: `SW=16`, `N=8`, all samples 0xFFFF. Without the macro → `sum=0xFFF8`, `sat=0`. With `PIPELINE_RESULT_ACC_SAT_EN` → `sum=0xFFFF`, `sat=1`.
- `clr` mid-frame: assert after 3 samples, then feed 8 samples of value 2 → `sum=16`, `max=2`, `overrun=0`. Repeat `clr` while in `HOLD` → `out_valid` drops the next cycle.
- Async reset: drop `rst_n` between clock edges mid-frame → all outputs reach their reset values before the next edge. After release, the first frame is correct.
